// File: rtl/act_buffer_pkg.sv
// act_buffer_pkg
// Shared constants and FSM state type for the activation buffer.
// Element width and FSM encodings normally come from the shared headers.
// Fallback definitions are provided here so the slice elaborates on its own
// when those headers are not on the include path.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif
`ifndef BIDL
`define BIDL 2'd0
`endif
`ifndef BLOD
`define BLOD 2'd1
`endif
`ifndef BPRC
`define BPRC 2'd2
`endif
`ifndef BDON
`define BDON 2'd3
`endif

package act_buffer_pkg;
  localparam int CH_N  = 32;
  localparam int POS_N = 12;
  localparam int DW_N  = `DATA_LEN;

  typedef enum logic [1:0] {
    ST_IDLE = `BIDL,
    ST_LOAD = `BLOD,
    ST_PROC = `BPRC,
    ST_DONE = `BDON
  } buf_state_e;
endpackage

// File: rtl/act_buffer_relu.sv
// relu_lane
// Combinational ReLU over one channel (POS signed elements of DW bits).
//   en   : 1 = clamp negative elements to zero, 0 = pass through
//   din  : POS elements, position p at [p*DW +: DW]
//   dout : same layout and width as din
module relu_lane #(
  parameter int POS = 12,
  parameter int DW  = 16
) (
  input  logic              en,
  input  logic [POS*DW-1:0] din,
  output logic [POS*DW-1:0] dout
);
  for (genvar p = 0; p < POS; p++) begin : g_pos
    assign dout[p*DW +: DW] = (en && din[p*DW+DW-1]) ? '0 : din[p*DW +: DW];
  end
endmodule

// File: rtl/act_buffer.sv
// act_buffer
// Captures a CH x POS layer result on the rising edge of in_valid, applies
// optional ReLU one channel per cycle, and writes it into one of two
// ping-pong banks. The oldest full bank is presented on q for the next layer.
//   clk, rst  : clock, asynchronous active-high reset
//   in_valid  : layer-complete level (only its rising edge starts a frame)
//   relu_en   : ReLU enable, sampled with the frame
//   d         : layer result, channel c / position p at [(c*POS+p)*DW +: DW]
//   rd_req    : pulse, consumer is done with the read bank
//   q         : read bank contents, same layout as d
//   q_valid   : read bank holds a complete frame
//   busy      : capture/processing in progress
//   drop      : sticky, a frame edge arrived with no room to take it
module act_buffer
  import act_buffer_pkg::*;
#(
  parameter int CH  = CH_N,
  parameter int POS = POS_N,
  parameter int DW  = DW_N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  relu_en,
  input  logic [CH*POS*DW-1:0]  d,
  input  logic                  rd_req,
  output logic [CH*POS*DW-1:0]  q,
  output logic                  q_valid,
  output logic                  busy,
  output logic                  drop
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  buf_state_e state, state_nxt;

  logic                            in_valid_q;
  logic                            frame_edge;
  logic                            accept;
  logic [CH-1:0][POS*DW-1:0]       stage;
  logic                            relu_sel;
  logic [CW-1:0]                   ch;
  logic [POS*DW-1:0]               lane_out;
  logic [CH-1:0]                   we;
  logic [1:0][CH-1:0][POS*DW-1:0]  bank;
  logic [1:0]                      full;
  logic                            wr_ptr;
  logic                            rd_ptr;

  assign frame_edge = in_valid & ~in_valid_q;
  // A frame needs both an idle engine and an empty target bank.
  assign accept     = frame_edge && (state == ST_IDLE) && !full[wr_ptr];

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_PROC;
      ST_PROC: if (ch == CW'(CH-1)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- edge detect / drop ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_valid_q <= 1'b0;
      drop       <= 1'b0;
    end else begin
      in_valid_q <= in_valid;
      if (frame_edge && !accept) drop <= 1'b1;
    end
  end

  // ---------------- staging / channel counter ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage    <= '0;
      relu_sel <= 1'b0;
      ch       <= '0;
    end else if (state == ST_LOAD) begin
      stage    <= d;
      relu_sel <= relu_en;
      ch       <= '0;
    end else if (state == ST_PROC) begin
      ch <= (ch == CW'(CH-1)) ? '0 : ch + CW'(1);
    end
  end

  relu_lane #(.POS(POS), .DW(DW)) u_relu (
    .en   (relu_sel),
    .din  (stage[ch]),
    .dout (lane_out)
  );

  // ---------------- bank write ----------------
  always_comb begin
    we = '0;
    for (int c = 0; c < CH; c++)
      we[c] = (state == ST_PROC) && (ch == CW'(c));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank <= '0;
    end else begin
      for (int c = 0; c < CH; c++)
        if (we[c]) bank[wr_ptr][c] <= lane_out;
    end
  end

  // ---------------- ping-pong bookkeeping ----------------
  // Read release and frame completion may land in the same cycle; they
  // always target different full bits because a frame only starts into an
  // empty bank while the read side either holds the other bank or nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (rd_req && full[rd_ptr]) begin
        full[rd_ptr] <= 1'b0;
        rd_ptr       <= ~rd_ptr;
      end
      if (state == ST_DONE) begin
        full[wr_ptr] <= 1'b1;
        wr_ptr       <= ~wr_ptr;
      end
    end
  end

  assign q       = bank[rd_ptr];
  assign q_valid = full[rd_ptr];
  assign busy    = (state != ST_IDLE);
endmodule

// File: tb/tb_act_buffer.sv
module tb_act_buffer;
  import act_buffer_pkg::*;
  localparam int W = CH_N*POS_N*DW_N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, relu_en, rd_req;
  logic [W-1:0] d, q;
  logic         q_valid, busy, drop;

  int n_chk  = 0;
  int n_fail = 0;

  act_buffer u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .relu_en(relu_en), .d(d),
    .rd_req(rd_req), .q(q), .q_valid(q_valid), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [DW_N-1:0] elem(input logic [W-1:0] f, input int c, input int p);
    return f[(c*POS_N+p)*DW_N +: DW_N];
  endfunction

  // kind 0: ch0 alternates +5/-3, ch31 all -1, others mixed sign
  // kind 1: off + c*POS + p (all positive)
  function automatic logic [W-1:0] pat_frame(input int kind, input int off);
    logic [W-1:0] f;
    int v;
    f = '0;
    for (int c = 0; c < CH_N; c++)
      for (int p = 0; p < POS_N; p++) begin
        if (kind == 1)                v = off + c*POS_N + p;
        else if (c == 0)              v = (p % 2 == 0) ? 5 : -3;
        else if (c == CH_N-1)         v = -1;
        else if ((c + p) % 4 == 0)    v = -(c*POS_N + p + 1);
        else                          v = c*POS_N + p + 7;
        f[(c*POS_N+p)*DW_N +: DW_N] = DW_N'(v);
      end
    return f;
  endfunction

  function automatic logic [W-1:0] relu_frame(input logic [W-1:0] f);
    logic [W-1:0] r;
    r = f;
    for (int i = 0; i < CH_N*POS_N; i++)
      if (f[i*DW_N+DW_N-1]) r[i*DW_N +: DW_N] = '0;
    return r;
  endfunction

  task automatic pulse_rd();
    rd_req = 1'b1; tick(); rd_req = 1'b0;
  endtask

  task automatic run_frame(input logic [W-1:0] f, input logic r, input string tag);
    d = f; relu_en = r; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 60 && busy; k++) tick();
    check({tag, "_done"}, {63'd0, busy}, 64'd0);
  endtask

  logic [W-1:0] f0, fa, fb, fc, fd, fe, fg, fh;
  int first;

  initial begin
    f0 = pat_frame(0, 0);
    fa = pat_frame(1, 100);  fb = pat_frame(1, 2000); fc = pat_frame(1, 5000);
    fd = pat_frame(1, 300);  fe = pat_frame(1, 700);
    fg = pat_frame(0, 0);    fh = pat_frame(1, 9000);

    // reset with inputs toggling
    rst = 1'b1; in_valid = 1'b0; relu_en = 1'b0; rd_req = 1'b0; d = '0;
    for (int k = 0; k < 4; k++) begin
      in_valid = k[0]; rd_req = ~k[0]; relu_en = k[1]; d = fa ^ {W{k[0]}};
      tick();
    end
    check("rst_q",       {63'd0, q == '0}, 64'd1);
    check("rst_q_valid", {63'd0, q_valid}, 64'd0);
    check("rst_busy",    {63'd0, busy},    64'd0);
    check("rst_drop",    {63'd0, drop},    64'd0);
    in_valid = 1'b0; rd_req = 1'b0;
    tick(); rst = 1'b0; tick(); tick();
    check("post_rst_busy",    {63'd0, busy},    64'd0);
    check("post_rst_q_valid", {63'd0, q_valid}, 64'd0);
    check("post_rst_drop",    {63'd0, drop},    64'd0);

    // ReLU frame, in_valid held 5 cycles, latency 34
    d = f0; relu_en = 1'b1; in_valid = 1'b1;
    tick();
    check("t1_busy_t0", {63'd0, busy}, 64'd1);
    first = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) in_valid = 1'b0;
      tick();
      if (q_valid && first < 0) first = k;
    end
    check("t1_latency",  64'(first), 64'd34);
    check("t1_busy_end", {63'd0, busy}, 64'd0);
    check("t1_no_drop",  {63'd0, drop}, 64'd0);
    check("t1_q",        {63'd0, q == relu_frame(f0)}, 64'd1);
    check("t1_ch0_p0",   64'(elem(q, 0, 0)), 64'd5);
    check("t1_ch0_p1",   64'(elem(q, 0, 1)), 64'd0);
    check("t1_ch0_p10",  64'(elem(q, 0, 10)), 64'd5);
    check("t1_ch31_p0",  64'(elem(q, 31, 0)), 64'd0);
    check("t1_ch31_p11", 64'(elem(q, 31, 11)), 64'd0);
    pulse_rd();
    check("t1_rd_empty", {63'd0, q_valid}, 64'd0);

    // pass-through frame keeps negatives
    run_frame(f0, 1'b0, "t2");
    check("t2_q_valid", {63'd0, q_valid}, 64'd1);
    check("t2_q",       {63'd0, q == f0}, 64'd1);
    check("t2_ch0_p1",  64'(elem(q, 0, 1)), 64'h0000_0000_0000_FFFD);
    check("t2_ch31_p5", 64'(elem(q, 31, 5)), 64'h0000_0000_0000_FFFF);
    pulse_rd();
    check("t2_rd_empty", {63'd0, q_valid}, 64'd0);

    // both banks full, third frame dropped
    run_frame(fa, 1'b1, "t3a");
    run_frame(fb, 1'b1, "t3b");
    d = fc; in_valid = 1'b1; tick(); in_valid = 1'b0; tick();
    check("t3_drop",    {63'd0, drop}, 64'd1);
    check("t3_busy",    {63'd0, busy}, 64'd0);
    check("t3_q_is_a",  {63'd0, q == fa}, 64'd1);
    check("t3_a_elem",  64'(elem(q, 3, 2)), 64'd138);
    pulse_rd();
    check("t3_q_is_b",  {63'd0, q == fb}, 64'd1);
    check("t3_b_valid", {63'd0, q_valid}, 64'd1);
    check("t3_b_elem",  64'(elem(q, 31, 11)), 64'd2383);
    pulse_rd();
    check("t3_empty",   {63'd0, q_valid}, 64'd0);

    // rd_req lands in the DONE cycle of frame B
    run_frame(fd, 1'b1, "t4a");
    d = fe; relu_en = 1'b1; in_valid = 1'b1; tick(); in_valid = 1'b0;
    for (int k = 1; k <= 33; k++) tick();
    check("t4_in_done",  {63'd0, busy}, 64'd1);
    check("t4_q_still_a", {63'd0, q == fd}, 64'd1);
    pulse_rd();
    check("t4_busy",     {63'd0, busy}, 64'd0);
    check("t4_q_valid",  {63'd0, q_valid}, 64'd1);
    check("t4_q_is_b",   {63'd0, q == fe}, 64'd1);
    pulse_rd();
    check("t4_empty",    {63'd0, q_valid}, 64'd0);

    // reset mid-PROC at ch=10, then a clean frame
    d = fg; relu_en = 1'b1; in_valid = 1'b1; tick(); in_valid = 1'b0;
    for (int k = 1; k <= 11; k++) tick();
    check("t5_busy_pre", {63'd0, busy}, 64'd1);
    rst = 1'b1; #1;
    check("t5_rst_q",       {63'd0, q == '0}, 64'd1);
    check("t5_rst_q_valid", {63'd0, q_valid}, 64'd0);
    check("t5_rst_busy",    {63'd0, busy},    64'd0);
    check("t5_rst_drop",    {63'd0, drop},    64'd0);
    tick(); rst = 1'b0; tick();
    run_frame(fh, 1'b1, "t5");
    check("t5_q_valid", {63'd0, q_valid}, 64'd1);
    check("t5_q",       {63'd0, q == fh}, 64'd1);
    check("t5_elem",    64'(elem(q, 10, 0)), 64'd9120);
    pulse_rd();
    check("t5_other_bank_clear", {63'd0, q == '0}, 64'd1);
    check("t5_empty",   {63'd0, q_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
